// File: rtl/seq_machine_n.sv
// seq_machine_n: N-bit state register stepping through binary, Gray or
// Johnson sequences, with direction control, parallel load and a one-cycle
// wrap flag. Storage can be built from D or JK flip-flops with identical
// cycle behaviour.
module seq_machine_n #(
  parameter int unsigned     WIDTH     = 3,
  parameter int unsigned     FF_STYLE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             x,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] S,
  output logic             F
);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] nxt_s;
  logic             nxt_f;
  logic [WIDTH-1:0] wrap_top;
  logic [WIDTH-1:0] bin_val;
  logic [WIDTH-1:0] inv_s;
  logic             john_valid;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state and wrap-flag decode; reset is applied at the register.
  always_comb begin
    nxt_s      = S;
    nxt_f      = 1'b0;
    wrap_top   = MSB_ONLY;
    bin_val    = '0;
    inv_s      = ~S;
    // Twisted-ring codes are a run of ones at the low end, or its complement.
    john_valid = ((S & (S + WIDTH'(1))) == '0) ||
                 ((inv_s & (inv_s + WIDTH'(1))) == '0);
    if (LOAD) begin
      nxt_s = D_IN;
    end else if (EN) begin
      case (MODE)
        MODE_BIN: begin
          wrap_top = ALL_ONES;
          nxt_s    = x ? (S - WIDTH'(1)) : (S + WIDTH'(1));
        end
        MODE_GRAY: begin
          bin_val = gray2bin(S);
          bin_val = x ? (bin_val - WIDTH'(1)) : (bin_val + WIDTH'(1));
          nxt_s   = bin_val ^ (bin_val >> 1);
        end
        MODE_JOHN: begin
          if (john_valid) begin
            nxt_s = x ? {~S[0], S[WIDTH-1:1]} : {S[WIDTH-2:0], ~S[WIDTH-1]};
          end else begin
            nxt_s = '0;
          end
        end
        default: nxt_s = S;
      endcase
      if (MODE != MODE_HOLD) begin
        nxt_f = x ? ((S == '0) && (nxt_s == wrap_top))
                  : ((S == wrap_top) && (nxt_s == '0));
      end
    end
  end

  // Wrap flag register.
  always_ff @(posedge CLK) begin
    if (RESET) F <= 1'b0;
    else       F <= nxt_f;
  end

  generate
    if (FF_STYLE == 0) begin : g_dff
      // D-style state storage.
      always_ff @(posedge CLK) begin
        if (RESET) S <= RESET_VAL;
        else       S <= nxt_s;
      end
    end else begin : g_jkff
      logic [WIDTH-1:0] j;
      logic [WIDTH-1:0] k;
      assign j = nxt_s & ~S;
      assign k = ~nxt_s & S;
      // JK-style state storage: Q+ = J&~Q | ~K&Q per bit.
      always_ff @(posedge CLK) begin
        if (RESET) S <= RESET_VAL;
        else       S <= (j & ~S) | (~k & S);
      end
    end
  endgenerate

endmodule

// File: tb/tb_seq_machine_n.sv
// Directed and randomized check of seq_machine_n (WIDTH=3), D and JK styles.
module tb_seq_machine_n;

  logic       clk;
  logic       reset;
  logic       x;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] d_in;
  logic [2:0] s_d, s_jk;
  logic       f_d, f_jk;

  int total = 0;
  int bad   = 0;

  seq_machine_n #(.WIDTH(3), .FF_STYLE(0), .RESET_VAL(3'b000)) dut_d (
    .CLK(clk), .RESET(reset), .x(x), .EN(en), .MODE(mode),
    .LOAD(load), .D_IN(d_in), .S(s_d), .F(f_d)
  );

  seq_machine_n #(.WIDTH(3), .FF_STYLE(1), .RESET_VAL(3'b000)) dut_jk (
    .CLK(clk), .RESET(reset), .x(x), .EN(en), .MODE(mode),
    .LOAD(load), .D_IN(d_in), .S(s_jk), .F(f_jk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One edge, then check both instances against the expected state/flag.
  task automatic step_chk(input string tag, input logic [2:0] es, input logic ef);
    @(posedge clk);
    #1;
    check({tag, " S"},    8'(s_d),  8'(es));
    check({tag, " F"},    8'(f_d),  8'(ef));
    check({tag, " S_jk"}, 8'(s_jk), 8'(es));
    check({tag, " F_jk"}, 8'(f_jk), 8'(ef));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_chk("reset", 3'b000, 1'b0);
    reset = 1'b0;
  endtask

  logic [2:0] gray_up [8];
  logic [2:0] gray_dn [8];
  logic [2:0] john_up [6];

  initial begin
    gray_up = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    gray_dn = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
    john_up = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

    reset = 1'b1; x = 1'b0; en = 1'b1; mode = 2'b00; load = 1'b0; d_in = 3'b000;
    #21;
    // Reset held: outputs stay at reset values.
    @(posedge clk); #1;
    check("t1 rst S", 8'(s_d), 8'h00);
    check("t1 rst F", 8'(f_d), 8'h00);
    step_chk("t1 rst hold", 3'b000, 1'b0);
    reset = 1'b0;

    // Binary up 1..7,0 with wrap flag on the return to zero.
    for (int i = 1; i <= 8; i++) begin
      step_chk("t1 bin up", 3'(i), i == 8);
    end
    // Binary down from 0: wraps to 7.
    x = 1'b1;
    step_chk("t1 bin dn", 3'b111, 1'b1);
    step_chk("t1 bin dn", 3'b110, 1'b0);
    step_chk("t1 bin dn", 3'b101, 1'b0);
    reset = 1'b1;
    step_chk("t1 mid rst", 3'b000, 1'b0);
    reset = 1'b0;

    // Down wrap from zero, flag lasts one cycle.
    step_chk("t2 dn wrap", 3'b111, 1'b1);
    step_chk("t2 dn", 3'b110, 1'b0);

    // Gray up and down.
    do_reset();
    mode = 2'b01; x = 1'b0;
    for (int i = 0; i < 8; i++) step_chk("t3 gray up", gray_up[i], i == 7);
    x = 1'b1;
    for (int i = 0; i < 8; i++) step_chk("t3 gray dn", gray_dn[i], i == 0);

    // Johnson up, then invalid load recovers to zero.
    do_reset();
    mode = 2'b10; x = 1'b0;
    for (int i = 0; i < 6; i++) step_chk("t4 john up", john_up[i], i == 5);
    load = 1'b1; d_in = 3'b101;
    step_chk("t4 load", 3'b101, 1'b0);
    load = 1'b0;
    step_chk("t4 invalid", 3'b000, 1'b0);
    // Johnson down from zero wraps to 100.
    x = 1'b1;
    step_chk("t4 john dn", 3'b100, 1'b1);
    step_chk("t4 john dn", 3'b110, 1'b0);

    // Priority and hold.
    mode = 2'b00; x = 1'b0;
    reset = 1'b1; load = 1'b1; en = 1'b1; d_in = 3'b110;
    step_chk("t5 rst>load", 3'b000, 1'b0);
    reset = 1'b0;
    step_chk("t5 load>en", 3'b110, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) step_chk("t5 hold", 3'b110, 1'b0);
    en = 1'b1; mode = 2'b11;
    step_chk("t5 mode hold", 3'b110, 1'b0);
    // Load all-ones then step up: wrap flag set.
    mode = 2'b00; load = 1'b1; d_in = 3'b111;
    step_chk("t5 load7", 3'b111, 1'b0);
    load = 1'b0;
    step_chk("t5 wrap", 3'b000, 1'b1);
    en = 1'b0;
    step_chk("t5 f drop", 3'b000, 1'b0);

    // D and JK instances in lockstep under random stimulus.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      x     = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      d_in  = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      check("t6 S eq", 8'(s_jk), 8'(s_d));
      check("t6 F eq", 8'(f_jk), 8'(f_d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
